// File: rtl/alu_ctrl_stage.sv
// ---------------------------------------------------------------------------
// alu_ctrl_stage
//
// Registered ALU-control decode stage for the RV32I pipeline, placed between
// instruction decode and execute. It translates (alu_op, opcode, funct3,
// funct7) into an ALU control code. It decodes the optional RV32M ops and
// flags illegal encodings. A one-deep valid/ready register provides
// backpressure and flush. A saturating counter of accepted illegal encodings
// is kept for debug.
//
// Parameters
//   M_EXT   1 = decode RV32M (funct7=0000001); 0 = treat those ops as illegal
//   CTRL_W  width of out_ctrl (>= 5); codes are zero-extended
//   CNT_W   width of illegal_cnt
//
// Ports
//   clk          clock, all state updates on the rising edge
//   reset        synchronous, active-high; highest priority
//   in_valid     upstream holds a decode request
//   in_ready     stage can accept this cycle (= !out_valid || out_ready)
//   alu_op       00 ld/st address, 01 branch compare, 10 R/I arith, 11 reserved
//   op           instruction opcode (op[5] selects R-type vs I-type)
//   funct3       instruction funct3
//   funct7       instruction funct7 (imm[11:5] for I-type)
//   flush        kills the registered entry and any same-cycle input
//   out_valid    registered result valid
//   out_ready    execute stage consumes the result
//   out_ctrl     ALU control code
//   out_is_m     result is an RV32M op (routed to the mul/div unit)
//   out_illegal  encoding is illegal (out_ctrl reads as add)
//   clr_cnt      synchronous clear of illegal_cnt (wins over an increment)
//   illegal_cnt  saturating count of accepted illegal encodings
// ---------------------------------------------------------------------------
module alu_ctrl_stage #(
  parameter int M_EXT  = 1,
  parameter int CTRL_W = 5,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        alu_op,
  input  logic [6:0]        op,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              out_is_m,
  output logic              out_illegal,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  illegal_cnt
);

  // ALU control codes (5-bit native width)
  localparam logic [4:0] C_ADD  = 5'd0;
  localparam logic [4:0] C_SUB  = 5'd1;
  localparam logic [4:0] C_AND  = 5'd2;
  localparam logic [4:0] C_OR   = 5'd3;
  localparam logic [4:0] C_XOR  = 5'd4;
  localparam logic [4:0] C_SLT  = 5'd5;
  localparam logic [4:0] C_SLTU = 5'd6;
  localparam logic [4:0] C_SLL  = 5'd7;
  localparam logic [4:0] C_SRL  = 5'd8;
  localparam logic [4:0] C_SRA  = 5'd9;
  localparam logic [4:0] C_MUL  = 5'd10;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  typedef struct packed {
    logic [4:0] code;
    logic       is_m;
    logic       illegal;
  } dec_t;

  // Full decode of one request. Illegal encodings are normalised to add with
  // is_m cleared so execute never sees a half-decoded op.
  function automatic dec_t decode(
    input logic [1:0] aop,
    input logic [6:0] opc,
    input logic [2:0] f3,
    input logic [6:0] f7
  );
    dec_t d;
    logic r_type;
    logic f7_zero;
    logic f7_alt;
    logic f7_m;
    d       = '{code: C_ADD, is_m: 1'b0, illegal: 1'b0};
    r_type  = opc[5];
    f7_zero = (f7 == F7_ZERO);
    f7_alt  = (f7 == F7_ALT);
    f7_m    = (f7 == F7_MEXT);
    unique case (aop)
      2'b00: d.code = C_ADD;
      2'b01: d.code = C_SUB;
      2'b10: begin
        if (r_type && f7_m) begin
          // RV32M: funct3 indexes mul..remu directly
          if (M_EXT != 0) begin
            d.code = C_MUL + {2'b00, f3};
            d.is_m = 1'b1;
          end else begin
            d.illegal = 1'b1;
          end
        end else begin
          unique case (f3)
            3'b000: begin
              // I-type addi carries an immediate in funct7, so it is ignored
              if (!r_type || f7_zero)  d.code    = C_ADD;
              else if (f7_alt)         d.code    = C_SUB;
              else                     d.illegal = 1'b1;
            end
            3'b001: begin
              if (f7_zero) d.code    = C_SLL;
              else         d.illegal = 1'b1;
            end
            3'b101: begin
              if (f7_zero)     d.code    = C_SRL;
              else if (f7_alt) d.code    = C_SRA;
              else             d.illegal = 1'b1;
            end
            default: begin
              if (r_type && !f7_zero) begin
                d.illegal = 1'b1;
              end else begin
                unique case (f3)
                  3'b010:  d.code = C_SLT;
                  3'b011:  d.code = C_SLTU;
                  3'b100:  d.code = C_XOR;
                  3'b110:  d.code = C_OR;
                  3'b111:  d.code = C_AND;
                  default: d.code = C_ADD;
                endcase
              end
            end
          endcase
        end
      end
      default: d.illegal = 1'b1;
    endcase
    if (d.illegal) begin
      d.code = C_ADD;
      d.is_m = 1'b0;
    end
    return d;
  endfunction

  // Saturating increment: holds at all-ones
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) return c;
    return c + 1'b1;
  endfunction

  dec_t              dec_p0;
  logic              accept_p0;

  logic              vld_p1;
  logic [4:0]        ctrl_p1;
  logic              is_m_p1;
  logic              ill_p1;
  logic [CNT_W-1:0]  cnt_p1;

  // ---- stage 0: combinational decode and handshake ----
  always_comb begin
    dec_p0    = decode(alu_op, op, funct3, funct7);
    in_ready  = !vld_p1 || out_ready;
    accept_p0 = in_valid && in_ready && !flush;
  end

  // ---- stage 1: output register and illegal counter ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= '0;
      is_m_p1 <= 1'b0;
      ill_p1  <= 1'b0;
      cnt_p1  <= '0;
    end else begin
      if (flush)          vld_p1 <= 1'b0;
      else if (accept_p0) vld_p1 <= 1'b1;
      else if (out_ready) vld_p1 <= 1'b0;

      // payload only moves on accept; after a drain it keeps stale values
      if (accept_p0) begin
        ctrl_p1 <= dec_p0.code;
        is_m_p1 <= dec_p0.is_m;
        ill_p1  <= dec_p0.illegal;
      end

      if (clr_cnt)                          cnt_p1 <= '0;
      else if (accept_p0 && dec_p0.illegal) cnt_p1 <= sat_inc(cnt_p1);
    end
  end

  assign out_valid   = vld_p1;
  assign out_ctrl    = CTRL_W'(ctrl_p1);
  assign out_is_m    = is_m_p1;
  assign out_illegal = ill_p1;
  assign illegal_cnt = cnt_p1;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_ctrl_stage
//
// Two instances share one input stream: "a" (M_EXT=1, CTRL_W=6, CNT_W=8) and
// "b" (M_EXT=0, CTRL_W=5, CNT_W=2). A behavioural model derived from the
// decode rules tracks each instance's register and counter state. Directed
// steps are followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_alu_ctrl_stage;

  logic       clk = 1'b0;
  logic       reset, in_valid, flush, out_ready, clr_cnt;
  logic [1:0] alu_op;
  logic [6:0] op, funct3_pad, funct7;
  logic [2:0] funct3;

  logic       a_rdy, a_vld, a_ism, a_ill;
  logic [5:0] a_ctrl;
  logic [7:0] a_cnt;
  logic       b_rdy, b_vld, b_ism, b_ill;
  logic [4:0] b_ctrl;
  logic [1:0] b_cnt;

  int nassert = 0;
  int nfail   = 0;

  // model state, index 0 = instance a, 1 = instance b
  bit m_vld[2];
  int m_code[2];
  bit m_ill[2];
  bit m_ism[2];
  int m_cnt[2];
  bit post_reset;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  always #5 clk = ~clk;

  alu_ctrl_stage #(.M_EXT(1), .CTRL_W(6), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_rdy),
    .alu_op(alu_op), .op(op), .funct3(funct3), .funct7(funct7),
    .flush(flush), .out_valid(a_vld), .out_ready(out_ready),
    .out_ctrl(a_ctrl), .out_is_m(a_ism), .out_illegal(a_ill),
    .clr_cnt(clr_cnt), .illegal_cnt(a_cnt)
  );

  alu_ctrl_stage #(.M_EXT(0), .CTRL_W(5), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_rdy),
    .alu_op(alu_op), .op(op), .funct3(funct3), .funct7(funct7),
    .flush(flush), .out_valid(b_vld), .out_ready(out_ready),
    .out_ctrl(b_ctrl), .out_is_m(b_ism), .out_illegal(b_ill),
    .clr_cnt(clr_cnt), .illegal_cnt(b_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference decode written from the instruction-set rules
  function automatic void ref_dec(input bit mext, input logic [1:0] aop,
                                  input logic [6:0] opc, input logic [2:0] f3,
                                  input logic [6:0] f7, output int code,
                                  output bit ill, output bit ism);
    bit r;
    r    = opc[5];
    code = 0;
    ill  = 0;
    ism  = 0;
    if (aop == 2'd0)      code = 0;
    else if (aop == 2'd1) code = 1;
    else if (aop == 2'd3) ill = 1;
    else if (r && f7 == 7'd1) begin
      if (mext) begin code = 10 + int'(f3); ism = 1; end
      else ill = 1;
    end else if (f3 == 3'd0) begin
      if (!r || f7 == 7'd0) code = 0;
      else if (f7 == 7'd32) code = 1;
      else ill = 1;
    end else if (f3 == 3'd5) begin
      if (f7 == 7'd0) code = 8;
      else if (f7 == 7'd32) code = 9;
      else ill = 1;
    end else if ((f3 == 3'd1 || r) && f7 != 7'd0) begin
      ill = 1;
    end else begin
      case (f3)
        3'd1: code = 7;
        3'd2: code = 5;
        3'd3: code = 6;
        3'd4: code = 4;
        3'd6: code = 3;
        default: code = 2;
      endcase
    end
    if (ill) begin code = 0; ism = 0; end
  endfunction

  task automatic drive(input bit v, input logic [1:0] aop, input logic [6:0] opc,
                       input logic [2:0] f3, input logic [6:0] f7, input bit rdy);
    in_valid  = v;
    alu_op    = aop;
    op        = opc;
    funct3    = f3;
    funct7    = f7;
    out_ready = rdy;
  endtask

  // One clock: check in_ready, advance the model, clock, compare outputs
  task automatic tick();
    bit exp_rdy, acc, ill;
    bit ism;
    int code, maxc;
    #1;
    exp_rdy = !m_vld[0] || out_ready;
    chk("a_in_ready", a_rdy, exp_rdy);
    chk("b_in_ready", b_rdy, exp_rdy);
    acc = in_valid && exp_rdy && !flush;
    for (int k = 0; k < 2; k++) begin
      ref_dec(k == 0, alu_op, op, funct3, funct7, code, ill, ism);
      maxc = (k == 0) ? 255 : 3;
      if (reset) begin
        m_vld[k] = 0; m_code[k] = 0; m_ill[k] = 0; m_ism[k] = 0; m_cnt[k] = 0;
      end else begin
        if (flush)          m_vld[k] = 0;
        else if (acc)       m_vld[k] = 1;
        else if (out_ready) m_vld[k] = 0;
        if (acc) begin m_code[k] = code; m_ill[k] = ill; m_ism[k] = ism; end
        if (clr_cnt)                      m_cnt[k] = 0;
        else if (acc && ill && m_cnt[k] < maxc) m_cnt[k] = m_cnt[k] + 1;
      end
    end
    post_reset = reset;
    @(posedge clk);
    #1;
    chk("a_out_valid", a_vld, m_vld[0]);
    chk("b_out_valid", b_vld, m_vld[1]);
    chk("a_illegal_cnt", a_cnt, m_cnt[0]);
    chk("b_illegal_cnt", b_cnt, m_cnt[1]);
    // payload is only defined while valid (and right after reset)
    if (m_vld[0] || post_reset) begin
      chk("a_out_ctrl", a_ctrl, m_code[0]);
      chk("a_out_is_m", a_ism, m_ism[0]);
      chk("a_out_illegal", a_ill, m_ill[0]);
      chk("b_out_ctrl", b_ctrl, m_code[1]);
      chk("b_out_is_m", b_ism, m_ism[1]);
      chk("b_out_illegal", b_ill, m_ill[1]);
    end
  endtask

  initial begin
    int sweep_exp[8];
    int rr;
    logic [6:0] f7r;
    sweep_exp = '{0, 7, 5, 6, 4, 8, 3, 2};
    for (int k = 0; k < 2; k++) begin
      m_vld[k] = 0; m_code[k] = 0; m_ill[k] = 0; m_ism[k] = 0; m_cnt[k] = 0;
    end
    post_reset = 0;
    reset = 1; flush = 0; clr_cnt = 0;
    drive(0, 2'b00, 7'd0, 3'd0, 7'd0, 1);
    @(posedge clk);
    tick();
    tick();
    reset = 0;
    chk("reset_a_ctrl", a_ctrl, 0);
    chk("reset_b_cnt", b_cnt, 0);
    #1;
    chk("reset_in_ready", a_rdy, 1);

    // R-type sweep
    for (int i = 0; i < 8; i++) begin
      drive(1, 2'b10, OP_R, 3'(i), 7'b0000000, 1);
      tick();
      chk("sweep_ctrl", a_ctrl, sweep_exp[i]);
      chk("sweep_vld", a_vld, 1);
    end

    // I-type addi with funct7 bits set, sub, srai
    drive(1, 2'b10, OP_I, 3'd0, 7'b0100000, 1); tick();
    chk("addi_ctrl", a_ctrl, 0);
    drive(1, 2'b10, OP_R, 3'd0, 7'b0100000, 1); tick();
    chk("sub_ctrl", a_ctrl, 1);
    drive(1, 2'b10, OP_I, 3'd5, 7'b0100000, 1); tick();
    chk("srai_ctrl", a_ctrl, 9);

    // M op: div on a, illegal on b
    drive(1, 2'b10, OP_R, 3'd4, 7'b0000001, 1); tick();
    chk("m_a_ctrl", a_ctrl, 14);
    chk("m_a_is_m", a_ism, 1);
    chk("m_b_ctrl", b_ctrl, 0);
    chk("m_b_ill", b_ill, 1);
    chk("m_b_cnt", b_cnt, 1);
    chk("m_a_cnt", a_cnt, 0);

    // backpressure: accept A (sub), hold with B (xor) waiting
    drive(1, 2'b10, OP_R, 3'd0, 7'b0100000, 1); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 2'b10, OP_R, 3'd4, 7'b0000000, 0); tick();
      chk("hold_ctrl", a_ctrl, 1);
      chk("hold_vld", a_vld, 1);
      chk("hold_rdy", a_rdy, 0);
    end
    drive(1, 2'b10, OP_R, 3'd4, 7'b0000000, 1); tick();
    chk("release_ctrl", a_ctrl, 4);

    // flush with an illegal encoding on the input
    flush = 1;
    drive(1, 2'b11, OP_R, 3'd0, 7'd0, 1); tick();
    flush = 0;
    chk("flush_vld", a_vld, 0);
    chk("flush_cnt", b_cnt, 1);

    // flush during hold, then accept the cycle after
    drive(1, 2'b00, OP_R, 3'd0, 7'd0, 1); tick();
    flush = 1;
    drive(1, 2'b01, OP_R, 3'd0, 7'd0, 0); tick();
    flush = 0;
    chk("flush_hold_vld", a_vld, 0);
    drive(1, 2'b01, OP_R, 3'd0, 7'd0, 0); tick();
    chk("after_flush_ctrl", a_ctrl, 1);

    // counter saturation on b (CNT_W=2)
    clr_cnt = 1; drive(0, 2'b00, OP_R, 3'd0, 7'd0, 1); tick(); clr_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1, 2'b11, OP_R, 3'd0, 7'd0, 1); tick();
      chk("sat_cnt", b_cnt, (i < 3) ? i + 1 : 3);
    end
    clr_cnt = 1; drive(1, 2'b11, OP_R, 3'd0, 7'd0, 1); tick(); clr_cnt = 0;
    chk("clr_wins", b_cnt, 0);

    // reset during hold
    drive(1, 2'b00, OP_R, 3'd0, 7'd0, 1); tick();
    drive(1, 2'b01, OP_R, 3'd0, 7'd0, 0); tick();
    reset = 1; tick(); reset = 0;
    chk("reset_hold_vld", a_vld, 0);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      rr = $urandom_range(0, 3);
      f7r = (rr == 0) ? 7'd0 : (rr == 1) ? 7'd32 : (rr == 2) ? 7'd1 : 7'($urandom);
      rr = $urandom_range(0, 3);
      drive($urandom_range(0, 3) != 0,
            ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b10,
            (rr == 0) ? 7'($urandom) : (rr == 1) ? OP_I : OP_R,
            3'($urandom), f7r, $urandom_range(0, 3) != 0);
      flush   = ($urandom_range(0, 15) == 0);
      clr_cnt = ($urandom_range(0, 31) == 0);
      reset   = ($urandom_range(0, 63) == 0);
      tick();
    end
    reset = 0; flush = 0; clr_cnt = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
